// File: rtl/mult_pkg.sv
// Shared types and default geometry for the chunked sequential multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      NEG,
      DONE
   } state_e;

   localparam int unsigned DefAWidth = 32;
   localparam int unsigned DefBWidth = 32;
   localparam int unsigned DefAChunk = 8;
   localparam int unsigned DefBChunk = 16;

endpackage

// File: rtl/mult_param_ctrl.sv
// Sequencer for the chunked multiplier: walks slice pairs (i inner, j outer),
// then optionally one negate cycle, then a one-cycle done pulse.
module mult_param_ctrl
   import mult_pkg::*;
#(
   parameter int unsigned NA = 4,
   parameter int unsigned NB = 2,
   localparam int unsigned IW = (NA > 1) ? $clog2(NA) : 1,
   localparam int unsigned JW = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          signed_mode_i,
   input  logic          a_msb_i,
   input  logic          b_msb_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          load_o,
   output logic          step_o,
   output logic          negate_o,
   output logic [IW-1:0] i_sel_o,
   output logic [JW-1:0] j_sel_o
);

   localparam logic [IW-1:0] ILast = IW'(NA - 1);
   localparam logic [JW-1:0] JLast = JW'(NB - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic          neg_q, neg_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         neg_q   <= neg_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      neg_d    = neg_q;
      load_o   = 1'b0;
      step_o   = 1'b0;
      negate_o = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               load_o  = 1'b1;
               state_d = CALC;
               i_d     = '0;
               j_d     = '0;
               neg_d   = signed_mode_i & (a_msb_i ^ b_msb_i);
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         CALC: begin
            step_o = 1'b1;
            if (i_q == ILast) begin
               i_d = '0;
               if (j_q == JLast) begin
                  j_d     = '0;
                  state_d = neg_q ? NEG : DONE;
               end else begin
                  j_d = j_q + JW'(1);
               end
            end else begin
               i_d = i_q + IW'(1);
            end
         end
         NEG: begin
            negate_o = 1'b1;
            state_d  = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o  = (state_q == CALC) || (state_q == NEG);
   assign done_o  = (state_q == DONE);
   assign i_sel_o = i_q;
   assign j_sel_o = j_q;

endmodule

// File: rtl/mult_param_seq.sv
// Sequential multiplier: one A_CHUNK x B_CHUNK partial product per cycle,
// accumulated at full width; signed mode multiplies magnitudes and negates last.
module mult_param_seq
   import mult_pkg::*;
#(
   parameter int unsigned A_WIDTH = DefAWidth,
   parameter int unsigned B_WIDTH = DefBWidth,
   parameter int unsigned A_CHUNK = DefAChunk,
   parameter int unsigned B_CHUNK = DefBChunk
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic                       signed_mode,
   input  logic [A_WIDTH-1:0]         a,
   input  logic [B_WIDTH-1:0]         b,
   output logic                       busy,
   output logic                       done,
   output logic [A_WIDTH+B_WIDTH-1:0] product
);

   localparam int unsigned PW  = A_WIDTH + B_WIDTH;
   localparam int unsigned PPW = A_CHUNK + B_CHUNK;
   localparam int unsigned NA  = A_WIDTH / A_CHUNK;
   localparam int unsigned NB  = B_WIDTH / B_CHUNK;
   localparam int unsigned IW  = (NA > 1) ? $clog2(NA) : 1;
   localparam int unsigned JW  = (NB > 1) ? $clog2(NB) : 1;

   logic [A_WIDTH-1:0] a_q, a_d, a_mag;
   logic [B_WIDTH-1:0] b_q, b_d, b_mag;
   logic [PW-1:0]      product_q, product_d, pp_shifted;
   logic [A_CHUNK-1:0] a_slice;
   logic [B_CHUNK-1:0] b_slice;
   logic [PPW-1:0]     pp;
   logic [31:0]        shamt;
   logic [IW-1:0]      i_sel;
   logic [JW-1:0]      j_sel;
   logic               load, step, negate;

   mult_param_ctrl #(
      .NA(NA),
      .NB(NB)
   ) u_ctrl (
      .clk_i        (clk),
      .rst_ni       (reset_n),
      .start_i      (start),
      .signed_mode_i(signed_mode),
      .a_msb_i      (a[A_WIDTH-1]),
      .b_msb_i      (b[B_WIDTH-1]),
      .busy_o       (busy),
      .done_o       (done),
      .load_o       (load),
      .step_o       (step),
      .negate_o     (negate),
      .i_sel_o      (i_sel),
      .j_sel_o      (j_sel)
   );

   // Negating the most-negative value yields 2^(W-1), which fits unsigned in W bits.
   always_comb begin
      a_mag = (signed_mode && a[A_WIDTH-1]) ? (~a + A_WIDTH'(1)) : a;
      b_mag = (signed_mode && b[B_WIDTH-1]) ? (~b + B_WIDTH'(1)) : b;
      a_d   = load ? a_mag : a_q;
      b_d   = load ? b_mag : b_q;
   end

   always_comb begin
      a_slice    = a_q[32'(i_sel) * A_CHUNK +: A_CHUNK];
      b_slice    = b_q[32'(j_sel) * B_CHUNK +: B_CHUNK];
      pp         = PPW'(a_slice) * PPW'(b_slice);
      shamt      = 32'(i_sel) * A_CHUNK + 32'(j_sel) * B_CHUNK;
      pp_shifted = PW'(pp) << shamt;
      product_d  = product_q;
      if (load) begin
         product_d = '0;
      end else if (step) begin
         product_d = product_q + pp_shifted;
      end else if (negate) begin
         product_d = ~product_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q       <= '0;
         b_q       <= '0;
         product_q <= '0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: doc/mult_param_seq.md
MULT_PARAM_SEQ -- requirements
Module: mult_param_seq

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32, multiplicand width in bits.
REQ-002 SHALL have parameter B_WIDTH, default 32, multiplier width in bits.
REQ-003 SHALL have parameter A_CHUNK, default 8, A slice width per partial product; A_WIDTH % A_CHUNK == 0.
REQ-004 SHALL have parameter B_CHUNK, default 16, B slice width per partial product; B_WIDTH % B_CHUNK == 0.
REQ-005 SHALL have port clk, input, 1, single clock; all flops on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, request a new multiplication.
REQ-008 SHALL have port signed_mode, input, 1, 1 = treat a, b as two's complement; sampled with start.
REQ-009 SHALL have port a, input, A_WIDTH, multiplicand; sampled with start.
REQ-010 SHALL have port b, input, B_WIDTH, multiplier; sampled with start.
REQ-011 SHALL have port busy, output, 1, high while computing.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when product is final.
REQ-013 SHALL have port product, output, A_WIDTH+B_WIDTH, registered result.

Function
REQ-014 NA = A_WIDTH/A_CHUNK, NB = B_WIDTH/B_CHUNK, NSTEP = NA*NB; defaults give NA=4, NB=2, NSTEP=8.
REQ-015 States: IDLE, CALC, NEG, DONE; busy=1 only in CALC and NEG; done=1 only in DONE.
REQ-016 Start accepted when state is IDLE or DONE and start=1 at edge E0; start in CALC/NEG is ignored with no side effects.
REQ-017 At acceptance: product<=0; step counters i<=0, j<=0; operand registers load a, b unchanged if signed_mode=0, else |a|, |b|; neg flag <= signed_mode & (a[MSB]^b[MSB]).
REQ-018 Most-negative operand (e.g. 0x80000000) has magnitude 2^(W-1), held unsigned in W bits with no overflow.
REQ-019 CALC step (i,j): product <= product + (A_reg slice i * B_reg slice j) << (i*A_CHUNK + j*B_CHUNK); i is the inner index, j the outer index, both starting at 0.
REQ-020 Step k is computed in the cycle after E_k and is written at E_{k+1}; after the last step (i=NA-1, j=NB-1) go to NEG if neg flag is set, else to DONE.
REQ-021 NEG: product <= two's complement of product in one cycle, then DONE.
REQ-022 DONE lasts exactly one cycle, then IDLE unless a new start is accepted (back-to-back, no bubble).
REQ-023 Latency from E0: done high in the cycle after edge E_NSTEP, or after E_{NSTEP+1} when negating.
REQ-024 product holds its value in IDLE/DONE until the next accepted start; final product is exact mod 2^(A_WIDTH+B_WIDTH).
REQ-025 Accumulator arithmetic SHALL be performed at full product width with no truncation of shifted partial products.

Reset
REQ-026 reset_n=0 SHALL immediately force state=IDLE, busy=0, done=0, product=0, counters=0, neg flag=0, including mid-CALC/NEG; the aborted operation produces no done.
REQ-027 First start SHALL be accepted at the first rising edge after reset_n deasserts.

Structure
REQ-028 Package mult_pkg SHALL hold the state enum typedef (IDLE, CALC, NEG, DONE) and default width/chunk constants.
REQ-029 Control (state register, i/j counters, busy/done, slice selects, neg control) SHALL live in sub-module mult_param_ctrl; datapath (operand regs, slice mux, multiplier, shifter, accumulator) in mult_param_seq.

Verification
REQ-030 Unsigned 0xFFFFFFFF x 0xFFFFFFFF, defaults -> product 0xFFFFFFFE00000001; done in the cycle after E8; busy high for 8 cycles.
REQ-031 signed_mode=1, a=0xFFFFFFFD (-3), b=5 -> product 0xFFFFFFFFFFFFFFF1; done in the cycle after E9; busy high for 9 cycles.
REQ-032 signed_mode=1, 0x80000000 x 0x80000000 -> 0x4000000000000000, no NEG cycle, done in the cycle after E8.
REQ-033 start pulsed in CALC step 3 -> ignored, result unchanged; separately reset_n=0 in step 5 -> busy=0, product=0 asynchronously, no done.
REQ-034 start=1 during DONE with new operands 3 x 7 -> accepted; next done shows 21 with no IDLE cycle in between.
REQ-035 A_WIDTH=B_WIDTH=16, A_CHUNK=8, B_CHUNK=16: 0xABCD x 0x1234 -> 0x0C374FA4 after NSTEP=2 cycles; random unsigned/signed sweep matches a reference model.
